// File: rtl/slider_movegen.sv
// slider_movegen: sliding-piece move generator; loads a 64-square board from SDRAM over
// Avalon-MM and writes one successor board per legal move along each enabled ray.
module slider_movegen #(
    parameter logic [7:0] DEFAULT_DIRS = 8'h55,
    parameter int         MAX_BOARDS   = 28,
    parameter int         MAX_DIST     = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest_o,
    input  logic [3:0]  slave_address_i,
    input  logic        slave_read_i,
    input  logic        slave_write_i,
    output logic [31:0] slave_readdata_o,
    input  logic [31:0] slave_writedata_i,
    input  logic        master_waitrequest_i,
    output logic [31:0] master_address_o,
    output logic        master_read_o,
    output logic        master_write_o,
    input  logic [31:0] master_readdata_i,
    input  logic        master_readdatavalid_i,
    output logic [31:0] master_writedata_o
);
    typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_WAIT, NEXT_DIR, STEP, CHECK, WR_SQ, DONE} state_t;
    localparam logic [31:0] MB = 32'(MAX_BOARDS);
    localparam logic [3:0]  MD = 4'(MAX_DIST);
    state_t      state_q, state_d;
    logic [31:0] src_q, dest_q, count_q, count_d;
    logic [2:0]  x_q, y_q, dir_q, dir_d, low;
    logic [7:0]  mask_q, rem_q, rem_d;
    logic [3:0]  rx_q, rx_d, ry_q, ry_d, dist_q, dist_d, dx, dy;
    logic [5:0]  k_q, k_d, sq, tgt;
    logic        cap_q, cap_d, start, cfg_wr, off, friendly;
    logic [7:0]  board_q [64];
    logic [7:0]  piece, tp, wr_byte;
    logic        unused_ok;
    assign unused_ok = &{1'b0, master_readdata_i[31:8], slave_read_i};
    assign start     = slave_write_i && slave_address_i == 4'd0;
    assign cfg_wr    = state_q == IDLE && slave_write_i;
    assign sq        = {y_q, x_q};
    assign tgt       = {ry_q[2:0], rx_q[2:0]};
    assign piece     = board_q[sq];
    assign tp        = board_q[tgt];
    // rx/ry are 4-bit two's complement: both -1 and 8 have bit 3 set
    assign off       = rx_q[3] || ry_q[3];
    assign friendly  = tp != 8'd0 && tp[7] == piece[7];
    assign dx = (dir_q inside {3'd1, 3'd2, 3'd3}) ? 4'd1 : (dir_q inside {3'd5, 3'd6, 3'd7}) ? 4'hF : 4'd0;
    assign dy = (dir_q inside {3'd7, 3'd0, 3'd1}) ? 4'd1 : (dir_q inside {3'd3, 3'd4, 3'd5}) ? 4'hF : 4'd0;
    assign wr_byte = k_q == sq ? 8'd0 : k_q == tgt ? piece : board_q[k_q];
    assign master_read_o       = state_q == LOAD_REQ;
    assign master_write_o      = state_q == WR_SQ;
    assign master_address_o    = state_q == WR_SQ ? dest_q + {count_q[25:0], k_q} : src_q + 32'(k_q);
    assign master_writedata_o  = {{24{wr_byte[7]}}, wr_byte};
    assign slave_readdata_o    = slave_address_i == 4'd0 ? count_q : 32'd0;
    assign slave_waitrequest_o = !rst_n || !(state_q == DONE || (state_q == IDLE && !start));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        dist_d  = dist_q;
        k_d     = k_q;
        cap_d   = cap_q;
        low     = 3'd0;
        for (int i = 7; i >= 0; i--) if (rem_q[i]) low = 3'(i);
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD_REQ;
                count_d = '0;
                k_d     = '0;
                rem_d   = mask_q;
            end
            LOAD_REQ: if (!master_waitrequest_i) state_d = LOAD_WAIT;
            LOAD_WAIT: if (master_readdatavalid_i) begin
                k_d     = k_q + 6'd1;
                state_d = k_q == 6'd63 ? NEXT_DIR : LOAD_REQ;
            end
            NEXT_DIR: if (piece == 8'd0 || rem_q == 8'd0) state_d = DONE;
            else begin
                dir_d   = low;
                rem_d   = rem_q & ~(8'd1 << low);
                rx_d    = {1'b0, x_q};
                ry_d    = {1'b0, y_q};
                dist_d  = '0;
                state_d = STEP;
            end
            STEP: begin
                rx_d    = rx_q + dx;
                ry_d    = ry_q + dy;
                dist_d  = dist_q + 4'd1;
                state_d = CHECK;
            end
            CHECK: if (off || dist_q > MD || friendly) state_d = NEXT_DIR;
            else begin
                cap_d   = tp != 8'd0;
                k_d     = '0;
                state_d = WR_SQ;
            end
            WR_SQ: if (!master_waitrequest_i) begin
                k_d = k_q + 6'd1;
                if (k_q == 6'd63) begin
                    count_d = count_q + 32'd1;
                    state_d = count_d == MB ? DONE : cap_q ? NEXT_DIR : STEP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            mask_q  <= DEFAULT_DIRS;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (cfg_wr && slave_address_i == 4'd5) mask_q <= slave_writedata_i[7:0];
        end
        if (cfg_wr && slave_address_i == 4'd1) src_q <= slave_writedata_i;
        if (cfg_wr && slave_address_i == 4'd2) dest_q <= slave_writedata_i;
        if (cfg_wr && slave_address_i == 4'd3) x_q <= slave_writedata_i[2:0];
        if (cfg_wr && slave_address_i == 4'd4) y_q <= slave_writedata_i[2:0];
        dir_q  <= dir_d;
        rem_q  <= rem_d;
        rx_q   <= rx_d;
        ry_q   <= ry_d;
        dist_q <= dist_d;
        k_q    <= k_d;
        cap_q  <= cap_d;
    end

    always_ff @(posedge clk)
        if (state_q == LOAD_WAIT && master_readdatavalid_i) board_q[k_q] <= master_readdata_i[7:0];
endmodule

// File: tb/tb_slider_movegen.sv
// tb_slider_movegen: directed vectors for slider_movegen against a chess-move reference,
// with an SDRAM model (optional random stalls) and a second instance capped at 3 boards.
module tb_slider_movegen;
    localparam int LIM = 20000;
    typedef struct {
        int x, y;
        bit setm;
        logic [7:0] mask, p;
        int fsq;
        logic [7:0] fp;
        int esq;
        logic [7:0] ep;
        bit stall;
        int exp_n, cb, csq;
        logic [7:0] cv;
    } vec_t;

    logic clk = 0, rst_n = 0, clr = 0, stall = 0;
    always #5 clk = ~clk;
    logic [3:0]  s_addr = '0;
    logic [31:0] s_wdata = '0, s_rdata0, s_rdata1;
    logic [1:0]  s_wr = '0, s_rd = '0, s_wreq;
    logic        m_wait = 0, m_read, m_write, m_rvalid = 0;
    logic [31:0] m_addr, m_rdata = '0, m_wdata;
    logic        n_wait = 0, n_read, n_write, n_rvalid = 0;
    logic [31:0] n_addr, n_rdata = '0, n_wdata;
    logic [31:0] srcmem [64];
    logic [31:0] dst [2048];
    logic [31:0] dst2 [2048];
    logic [7:0]  expb [28][64];
    int DX[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int DY[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    int wcnt = 0, wcnt2 = 0, stray1 = 0, stray2 = 0, both = 0, pend = 0, dly = 0, npend = 0;
    logic [5:0] raddr = '0, nraddr = '0;
    int checks = 0, failures = 0;
    vec_t vecs[6];

    slider_movegen dut (
        .clk(clk), .rst_n(rst_n), .slave_waitrequest_o(s_wreq[0]), .slave_address_i(s_addr),
        .slave_read_i(s_rd[0]), .slave_write_i(s_wr[0]), .slave_readdata_o(s_rdata0),
        .slave_writedata_i(s_wdata), .master_waitrequest_i(m_wait), .master_address_o(m_addr),
        .master_read_o(m_read), .master_write_o(m_write), .master_readdata_i(m_rdata),
        .master_readdatavalid_i(m_rvalid), .master_writedata_o(m_wdata));

    slider_movegen #(.MAX_BOARDS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .slave_waitrequest_o(s_wreq[1]), .slave_address_i(s_addr),
        .slave_read_i(s_rd[1]), .slave_write_i(s_wr[1]), .slave_readdata_o(s_rdata1),
        .slave_writedata_i(s_wdata), .master_waitrequest_i(n_wait), .master_address_o(n_addr),
        .master_read_o(n_read), .master_write_o(n_write), .master_readdata_i(n_rdata),
        .master_readdatavalid_i(n_rvalid), .master_writedata_o(n_wdata));

    always @(posedge clk) begin
        m_wait   <= stall && ($urandom_range(0, 1) == 1);
        m_rvalid <= 1'b0;
        if (clr) for (int i = 0; i < 2048; i++) dst[i] <= 32'hDEADBEEF;
        if (!rst_n) pend <= 0;
        else begin
            if (pend != 0 && dly == 0) begin
                m_rvalid <= 1'b1;
                m_rdata  <= srcmem[raddr];
                pend     <= 0;
            end else if (pend != 0) dly <= dly - 1;
            if (m_read && !m_wait) begin
                pend  <= 1;
                raddr <= 6'(m_addr - 32'h100);
                dly   <= stall ? int'($urandom_range(0, 5)) : 0;
            end
            if (m_write && !m_wait) begin
                wcnt <= wcnt + 1;
                if (m_addr[31:11] == 21'd2) dst[m_addr[10:0]] <= m_wdata;
                else stray1 <= stray1 + 1;
            end
            if (m_read && m_write) both <= both + 1;
        end
    end

    always @(posedge clk) begin
        n_rvalid <= 1'b0;
        if (clr) for (int i = 0; i < 2048; i++) dst2[i] <= 32'hDEADBEEF;
        if (!rst_n) npend <= 0;
        else begin
            if (npend != 0) begin
                n_rvalid <= 1'b1;
                n_rdata  <= srcmem[nraddr];
                npend    <= 0;
            end
            if (n_read) begin
                npend  <= 1;
                nraddr <= 6'(n_addr - 32'h100);
            end
            if (n_write) begin
                wcnt2 <= wcnt2 + 1;
                if (n_addr[31:11] == 21'd2) dst2[n_addr[10:0]] <= n_wdata;
                else stray2 <= stray2 + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wr(input int u, input logic [3:0] a, input logic [31:0] d, output bit ok);
        int n = 0;
        @(negedge clk);
        s_addr = a; s_wdata = d; s_wr[u] = 1'b1;
        #1;
        while (s_wreq[u] && n < LIM) begin @(negedge clk); n++; end
        ok = !s_wreq[u];
        @(negedge clk);
        s_wr[u] = 1'b0;
    endtask

    task automatic rd(input int u, input logic [3:0] a, output logic [31:0] d, output bit ok);
        int n = 0;
        @(negedge clk);
        s_addr = a; s_rd[u] = 1'b1;
        #1;
        while (s_wreq[u] && n < LIM) begin @(negedge clk); n++; end
        ok = !s_wreq[u];
        d  = u == 0 ? s_rdata0 : s_rdata1;
        @(negedge clk);
        s_rd[u] = 1'b0;
    endtask

    task automatic setup(input vec_t v);
        for (int k = 0; k < 64; k++) srcmem[k] = 32'hA5A5A500;
        srcmem[v.y * 8 + v.x][7:0] = v.p;
        if (v.fsq >= 0) srcmem[v.fsq][7:0] = v.fp;
        if (v.esq >= 0) srcmem[v.esq][7:0] = v.ep;
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic model(input vec_t v, input int maxb, output int n);
        logic [7:0] b [64];
        logic [7:0] p, t;
        int cx, cy;
        for (int k = 0; k < 64; k++) b[k] = srcmem[k][7:0];
        p = b[v.y * 8 + v.x];
        n = 0;
        if (p != 8'd0)
            for (int d = 0; d < 8; d++) if (v.mask[d]) begin
                cx = v.x; cy = v.y;
                for (int s = 1; s <= 7 && n < maxb; s++) begin
                    cx += DX[d]; cy += DY[d];
                    if (cx < 0 || cx > 7 || cy < 0 || cy > 7) break;
                    t = b[cy * 8 + cx];
                    if (t != 8'd0 && t[7] == p[7]) break;
                    for (int k = 0; k < 64; k++) expb[n][k] = b[k];
                    expb[n][v.y * 8 + v.x] = 8'd0;
                    expb[n][cy * 8 + cx] = p;
                    n++;
                    if (t != 8'd0) break;
                end
            end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit ok;
        int mn, w0, bad;
        logic [31:0] d, want;
        setup(v);
        stall = v.stall;
        model(v, 28, mn);
        if (v.setm) wr(0, 4'd5, {24'h0, v.mask}, ok);
        wr(0, 4'd1, 32'h100, ok);
        wr(0, 4'd2, 32'h1000, ok);
        wr(0, 4'd3, 32'(v.x), ok);
        wr(0, 4'd4, 32'(v.y), ok);
        w0 = wcnt;
        wr(0, 4'd0, 32'h0, ok);
        chk({tag, "_start_done"}, 32'(ok), 32'd1);
        stall = 1'b0;
        rd(0, 4'd0, d, ok);
        chk({tag, "_count"}, d, 32'(v.exp_n));
        chk({tag, "_writes"}, 32'(wcnt - w0), 32'(v.exp_n * 64));
        bad = 0;
        for (int n = 0; n < mn; n++)
            for (int k = 0; k < 64; k++) begin
                want = {{24{expb[n][k][7]}}, expb[n][k]};
                if (dst[n * 64 + k] !== want) bad++;
            end
        chk({tag, "_board_words_wrong"}, 32'(bad), 32'd0);
        if (v.cb >= 0) chk({tag, "_spot"}, dst[v.cb * 64 + v.csq], {{24{v.cv[7]}}, v.cv});
    endtask

    initial begin
        bit ok;
        int n, w0;
        logic [31:0] d;
        vecs[0] = '{0, 0, 1'b0, 8'h55, 8'h04, -1, 8'h00, -1, 8'h00, 1'b0, 14, 0, 8, 8'h04};
        vecs[1] = '{3, 3, 1'b1, 8'hFF, 8'h05, 43, 8'h01, 45, 8'hFF, 1'b0, 22, 2, 45, 8'h05};
        vecs[2] = '{7, 7, 1'b1, 8'hAA, 8'hFD, -1, 8'h00, 45, 8'h02, 1'b0, 2, 1, 45, 8'hFD};
        vecs[3] = '{2, 2, 1'b1, 8'hFF, 8'h00, -1, 8'h00, -1, 8'h00, 1'b0, 0, -1, 0, 8'h00};
        vecs[4] = '{7, 0, 1'b1, 8'h55, 8'h04, 6, 8'h01, -1, 8'h00, 1'b1, 7, 6, 63, 8'h04};
        vecs[5] = '{3, 3, 1'b1, 8'hFF, 8'h05, 43, 8'h01, 45, 8'hFF, 1'b1, 22, 2, 45, 8'h05};
        repeat (3) @(negedge clk);
        chk("rst_waitrequest", 32'(s_wreq), 32'd3);
        chk("rst_master_read", 32'(m_read), 32'd0);
        chk("rst_master_write", 32'(m_write), 32'd0);
        rst_n = 1'b1;
        rd(0, 4'd0, d, ok);
        chk("rst_count", d, 32'd0);
        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // capped instance: rook on an empty board stops after three boards
        setup(vecs[0]);
        wr(1, 4'd1, 32'h100, ok);
        wr(1, 4'd2, 32'h1000, ok);
        wr(1, 4'd3, 32'd0, ok);
        wr(1, 4'd4, 32'd0, ok);
        wr(1, 4'd0, 32'd0, ok);
        chk("cap_start_done", 32'(ok), 32'd1);
        rd(1, 4'd0, d, ok);
        chk("cap_count", d, 32'd3);
        chk("cap_writes", 32'(wcnt2), 32'd192);
        chk("cap_b2_target", dst2[128 + 24], 32'd4);
        chk("cap_b2_source", dst2[128], 32'd0);
        chk("cap_no_b3", dst2[192], 32'hDEADBEEF);

        // reset while a board is being written
        setup(vecs[0]);
        wr(0, 4'd5, 32'h55, ok);
        wr(0, 4'd1, 32'h100, ok);
        wr(0, 4'd2, 32'h1000, ok);
        wr(0, 4'd3, 32'd0, ok);
        wr(0, 4'd4, 32'd0, ok);
        @(negedge clk);
        s_addr = 4'd0; s_wr[0] = 1'b1;
        n = 0;
        while (!m_write && n < LIM) begin @(negedge clk); n++; end
        chk("mid_saw_write", 32'(m_write), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_write_dropped", 32'(m_write), 32'd0);
        chk("mid_waitrequest", 32'(s_wreq[0]), 32'd1);
        s_wr[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w0 = wcnt;
        repeat (10) @(negedge clk);
        chk("mid_no_traffic", 32'(wcnt - w0) + 32'(m_read), 32'd0);
        run_vec(vecs[1], "post_rst");

        chk("never_both_strobes", 32'(both), 32'd0);
        chk("no_stray_writes", 32'(stray1 + stray2), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
